// File: rtl/decode_stage_if.sv
// ---------------------------------------------------------------------------
// decode_stage_if
// Bundles the decode stage's upstream handshake, write-back port and
// downstream operand bus into one interface.
//   master : the side that feeds instructions, write-backs and out_ready
//   slave  : the decode stage itself
// Parameters DATA_W / AW must match the decode_stage instance using it.
// ---------------------------------------------------------------------------
interface decode_stage_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  // upstream instruction handshake
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instruction;
  logic              flush;

  // write-back port into the register file
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;

  // downstream decoded operand bus
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] rs;
  logic [DATA_W-1:0] rt;
  logic [AW-1:0]     rs_addr;
  logic [AW-1:0]     rt_addr;
  logic [AW-1:0]     rd_addr;
  logic [4:0]        shamt;
  logic [5:0]        opcode;
  logic [DATA_W-1:0] extended_imm;

  modport master (
    output in_valid, instruction, flush,
    output wb_en, wb_addr, wb_data,
    output out_ready,
    input  in_ready, out_valid,
    input  rs, rt, rs_addr, rt_addr, rd_addr, shamt, opcode, extended_imm
  );

  modport slave (
    input  in_valid, instruction, flush,
    input  wb_en, wb_addr, wb_data,
    input  out_ready,
    output in_ready, out_valid,
    output rs, rt, rs_addr, rt_addr, rd_addr, shamt, opcode, extended_imm
  );
endinterface

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// MIPS-style decode stage: register file plus a one-entry output register
// with valid/ready handshaking. An accepted instruction is split into its
// fields, its rs/rt registers are read and its immediate is extended; the
// results appear one cycle later and are held until taken downstream.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst_n  : synchronous active-low reset (clears outputs and register file)
//   bus    : decode_stage_if.slave
//            in_valid/in_ready/instruction/flush  upstream handshake
//            wb_en/wb_addr/wb_data                register write-back
//            out_valid/out_ready + operand fields downstream handshake
//
// Build option
//   DECODE_STAGE_BYPASS_EN : forward a same-edge write-back into captured
//   and stalled rs/rt operands. Undefined: operands always see the register
//   value from before the write and held operands never change.
//
// Assumes AW <= 5 (register fields are 5 bits) and DATA_W > 16.
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int AW      = $clog2(REG_CNT)
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_c;
  logic              capture;

  logic [DATA_W-1:0] regs [REG_CNT];

  logic [5:0]        f_op;
  logic [4:0]        f_rs, f_rt, f_rd, f_shamt;
  logic [15:0]       f_imm;
  logic [AW-1:0]     a_rs, a_rt, a_rd;
  logic              zero_ext;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rs_read, rt_read;

  logic [DATA_W-1:0] rs_q, rt_q, imm_q;
  logic [AW-1:0]     rs_addr_q, rt_addr_q, rd_addr_q;
  logic [4:0]        shamt_q;
  logic [5:0]        opcode_q;

  logic              unused_ok;

  // Field extraction; register fields are truncated to the register file's
  // address width, shamt and opcode are taken whole.
  assign f_op    = bus.instruction[31:26];
  assign f_rs    = bus.instruction[25:21];
  assign f_rt    = bus.instruction[20:16];
  assign f_rd    = bus.instruction[15:11];
  assign f_shamt = bus.instruction[10:6];
  assign f_imm   = bus.instruction[15:0];
  assign a_rs    = f_rs[AW-1:0];
  assign a_rt    = f_rt[AW-1:0];
  assign a_rd    = f_rd[AW-1:0];

  // funct bits and any truncated address bits are not needed here
  assign unused_ok = ^{bus.instruction[5:0], f_rs, f_rt, f_rd};

  // andi/ori/xori use a zero-extended immediate, everything else sign-extends
  assign zero_ext = (f_op == 6'h0C) || (f_op == 6'h0D) || (f_op == 6'h0E);
  assign imm_ext  = zero_ext ? {{(DATA_W-16){1'b0}}, f_imm}
                             : {{(DATA_W-16){f_imm[15]}}, f_imm};

  // Register read ports. Register 0 is forced to zero on read so it never
  // needs special handling in the write path beyond ignoring writes.
  always_comb begin
    rs_read = (a_rs == '0) ? '0 : regs[a_rs];
    rt_read = (a_rt == '0) ? '0 : regs[a_rt];
`ifdef DECODE_STAGE_BYPASS_EN
    if (bus.wb_en && (a_rs != '0) && (bus.wb_addr == a_rs)) rs_read = bus.wb_data;
    if (bus.wb_en && (a_rt != '0) && (bus.wb_addr == a_rt)) rt_read = bus.wb_data;
`endif
  end

  // Handshake state: EMPTY accepts freely, FULL accepts only when the held
  // operands leave this same cycle. Flush wins over everything.
  always_comb begin
    state_d    = state_q;
    in_ready_c = (state_q == ST_EMPTY) || bus.out_ready;
    capture    = bus.in_valid && in_ready_c && !bus.flush;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else if (capture) begin
      state_d = ST_FULL;
    end else if ((state_q == ST_FULL) && bus.out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Register file: write-back is independent of the handshake; reset clears
  // every entry and beats a write on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wb_en && (bus.wb_addr != '0)) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

`ifdef DECODE_STAGE_BYPASS_EN
  logic stall;
  logic hit_rs_held, hit_rt_held;

  // A write landing on a held, still-stalled operand refreshes it so the
  // consumer never sees a stale value.
  assign stall       = (state_q == ST_FULL) && !bus.out_ready && !bus.flush;
  assign hit_rs_held = bus.wb_en && (rs_addr_q != '0) && (bus.wb_addr == rs_addr_q);
  assign hit_rt_held = bus.wb_en && (rt_addr_q != '0) && (bus.wb_addr == rt_addr_q);
`endif

  // Output register: load on capture, otherwise hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_q      <= '0;
      rt_q      <= '0;
      imm_q     <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      shamt_q   <= '0;
      opcode_q  <= '0;
    end else if (capture) begin
      rs_q      <= rs_read;
      rt_q      <= rt_read;
      imm_q     <= imm_ext;
      rs_addr_q <= a_rs;
      rt_addr_q <= a_rt;
      rd_addr_q <= a_rd;
      shamt_q   <= f_shamt;
      opcode_q  <= f_op;
    end
`ifdef DECODE_STAGE_BYPASS_EN
    else if (stall) begin
      if (hit_rs_held) rs_q <= bus.wb_data;
      if (hit_rt_held) rt_q <= bus.wb_data;
    end
`endif
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = (state_q == ST_FULL);
  assign bus.rs           = rs_q;
  assign bus.rt           = rt_q;
  assign bus.extended_imm = imm_q;
  assign bus.rs_addr      = rs_addr_q;
  assign bus.rt_addr      = rt_addr_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.shamt        = shamt_q;
  assign bus.opcode       = opcode_q;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
// Self-checking bench for decode_stage. A reference register file and
// handshake model predict each captured result; predictions are queued when
// the instruction is driven and popped when the stage presents its output.
// Honours DECODE_STAGE_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_decode_stage;
  localparam int DATA_W  = 32;
  localparam int REG_CNT = 32;
  localparam int AW      = 5;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [4:0]  shamt;
    logic [5:0]  opcode;
    logic [31:0] imm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  int   tests_run    = 0;
  int   tests_failed = 0;

  logic [31:0] mregs [REG_CNT];
  bit          mvalid;
  bit          newcap;
  exp_t        q[$];
  exp_t        held;

  always #5 clk = ~clk;

  decode_stage_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

  decode_stage #(
    .DATA_W (DATA_W),
    .REG_CNT(REG_CNT),
    .AW     (AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Expected decode of an instruction against the model register file and
  // the write-back currently being driven.
  function automatic exp_t predict(input logic [31:0] ins);
    exp_t e;
    e.opcode  = ins[31:26];
    e.rs_addr = ins[25:21];
    e.rt_addr = ins[20:16];
    e.rd_addr = ins[15:11];
    e.shamt   = ins[10:6];
    if (e.opcode == 6'h0C || e.opcode == 6'h0D || e.opcode == 6'h0E)
      e.imm = {16'h0000, ins[15:0]};
    else
      e.imm = {{16{ins[15]}}, ins[15:0]};
    e.rs = (e.rs_addr == 5'd0) ? 32'h0 : mregs[e.rs_addr];
    e.rt = (e.rt_addr == 5'd0) ? 32'h0 : mregs[e.rt_addr];
`ifdef DECODE_STAGE_BYPASS_EN
    if (bus.wb_en && e.rs_addr != 5'd0 && bus.wb_addr == e.rs_addr) e.rs = bus.wb_data;
    if (bus.wb_en && e.rt_addr != 5'd0 && bus.wb_addr == e.rt_addr) e.rt = bus.wb_data;
`endif
    return e;
  endfunction

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.instruction = 32'h0;
    bus.flush       = 1'b0;
    bus.wb_en       = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.out_ready   = 1'b1;
  endtask

  // One clock edge: predict acceptance, advance, then update the model.
  // Outputs are sampled 1 time unit after the edge by the callers.
  task automatic tick();
    bit acc;
    acc = rst_n && bus.in_valid && (!mvalid || bus.out_ready) && !bus.flush;
    if (acc) q.push_back(predict(bus.instruction));
    @(posedge clk);
    #1;
    newcap = 1'b0;
    if (!rst_n) begin
      foreach (mregs[i]) mregs[i] = 32'h0;
      mvalid = 1'b0;
      q.delete();
      held = '{default: '0};
    end else begin
`ifdef DECODE_STAGE_BYPASS_EN
      if (mvalid && !bus.out_ready && !bus.flush && bus.wb_en) begin
        if (held.rs_addr != 5'd0 && bus.wb_addr == held.rs_addr) held.rs = bus.wb_data;
        if (held.rt_addr != 5'd0 && bus.wb_addr == held.rt_addr) held.rt = bus.wb_data;
      end
`endif
      if (bus.wb_en && bus.wb_addr != '0) mregs[bus.wb_addr] = bus.wb_data;
      if (bus.flush) begin
        mvalid = 1'b0;
      end else if (acc) begin
        mvalid = 1'b1;
        newcap = 1'b1;
        held   = q.pop_front();
      end else if (mvalid && bus.out_ready) begin
        mvalid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    tests_run++;
    if (bus.rs !== 32'h0 || bus.rt !== 32'h0 || bus.extended_imm !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_operands: got rs=%h rt=%h imm=%h expected all 0",
               bus.rs, bus.rt, bus.extended_imm);
    end
    tests_run++;
    if (bus.opcode !== 6'h0 || bus.shamt !== 5'h0 || bus.rs_addr !== 5'h0 ||
        bus.rt_addr !== 5'h0 || bus.rd_addr !== 5'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_fields: got op=%h sh=%h a=%h/%h/%h expected all 0",
               bus.opcode, bus.shamt, bus.rs_addr, bus.rt_addr, bus.rd_addr);
    end
    idle();
  endtask

  task automatic test_basic_read();
    idle();
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd5;
    bus.wb_data = 32'h0000_1234;
    tick();
    idle();
    bus.instruction = enc_r(5'd5, 5'd0, 5'd1, 5'd0, 6'h20);
    bus.in_valid    = 1'b1;
    tick();
    idle();
    tests_run++;
    if (bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL basic_out_valid: got %b expected 1", bus.out_valid);
    end
    tests_run++;
    if (bus.rs !== 32'h0000_1234) begin
      tests_failed++;
      $display("[TB] FAIL basic_rs: got %h expected 00001234", bus.rs);
    end
    tests_run++;
    if (bus.rt !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL basic_rt: got %h expected 00000000", bus.rt);
    end
    tests_run++;
    if (bus.rd_addr !== held.rd_addr || bus.rs_addr !== held.rs_addr ||
        bus.opcode !== held.opcode || bus.extended_imm !== held.imm) begin
      tests_failed++;
      $display("[TB] FAIL basic_fields: got rd=%h rs=%h op=%h imm=%h expected %h %h %h %h",
               bus.rd_addr, bus.rs_addr, bus.opcode, bus.extended_imm,
               held.rd_addr, held.rs_addr, held.opcode, held.imm);
    end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.rs !== 32'h0000_1234) begin
      tests_failed++;
      $display("[TB] FAIL basic_drain: got valid=%b rs=%h expected 0 00001234",
               bus.out_valid, bus.rs);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_cap, exp_stall;
`ifdef DECODE_STAGE_BYPASS_EN
    exp_cap   = 32'hAAAA_5555;
    exp_stall = 32'h1111_2222;
`else
    exp_cap   = 32'h0;
    exp_stall = 32'h0;
`endif
    idle();
    bus.wb_en       = 1'b1;
    bus.wb_addr     = 5'd3;
    bus.wb_data     = 32'hAAAA_5555;
    bus.instruction = enc_r(5'd3, 5'd3, 5'd2, 5'd0, 6'h20);
    bus.in_valid    = 1'b1;
    tick();
    idle();
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.rs !== exp_cap || bus.rs !== held.rs) begin
      tests_failed++;
      $display("[TB] FAIL bypass_capture_rs: got %h expected %h", bus.rs, exp_cap);
    end
    tests_run++;
    if (bus.rt !== exp_cap) begin
      tests_failed++;
      $display("[TB] FAIL bypass_capture_rt: got %h expected %h", bus.rt, exp_cap);
    end
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd3;
    bus.wb_data = 32'h1111_2222;
    tick();
    bus.wb_en = 1'b0;
    tests_run++;
    if (bus.rs !== exp_stall || bus.rs !== held.rs) begin
      tests_failed++;
      $display("[TB] FAIL bypass_stall_rs: got %h expected %h", bus.rs, exp_stall);
    end
    bus.out_ready = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_back_to_back_imm();
    logic [5:0]  ops  [4];
    logic [31:0] exps [4];
    ops  = '{6'h0D, 6'h08, 6'h0C, 6'h0E};
    exps = '{32'h0000_8001, 32'hFFFF_8001, 32'h0000_8001, 32'h0000_8001};
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.instruction = enc_i(ops[i], 5'd0, 5'd4, 16'h8001);
      bus.in_valid    = 1'b1;
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.extended_imm !== exps[i] || bus.opcode !== ops[i]) begin
        tests_failed++;
        $display("[TB] FAIL imm_op%h: got valid=%b imm=%h op=%h expected 1 %h %h",
                 ops[i], bus.out_valid, bus.extended_imm, bus.opcode, exps[i], ops[i]);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_stall_flush();
    idle();
    bus.instruction = enc_r(5'd5, 5'd3, 5'd7, 5'd9, 6'h00);
    bus.in_valid    = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.instruction = enc_i(6'h08, 5'd1, 5'd2, 16'(i + 16'h100));
      bus.in_valid    = 1'b1;
      tick();
      tests_run++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL stall_handshake_%0d: got ready=%b valid=%b expected 0 1",
                 i, bus.in_ready, bus.out_valid);
      end
      tests_run++;
      if (bus.rs !== held.rs || bus.rd_addr !== 5'd7 || bus.shamt !== 5'd9 ||
          bus.extended_imm !== held.imm) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold_%0d: got rs=%h rd=%h sh=%h imm=%h expected %h 07 09 %h",
                 i, bus.rs, bus.rd_addr, bus.shamt, bus.extended_imm, held.rs, held.imm);
      end
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL flush: got valid=%b ready=%b expected 0 1", bus.out_valid, bus.in_ready);
    end
    idle();
  endtask

  task automatic test_r0_and_stall_reset();
    idle();
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd0;
    bus.wb_data = 32'hFFFF_FFFF;
    tick();
    idle();
    bus.instruction = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h20);
    bus.in_valid    = 1'b1;
    tick();
    tests_run++;
    if (bus.rs !== 32'h0 || bus.rt !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL r0_read: got rs=%h rt=%h expected 0 0", bus.rs, bus.rt);
    end
    idle();
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd5;
    bus.wb_data = 32'h0000_0055;
    tick();
    idle();
    bus.instruction = enc_i(6'h08, 5'd5, 5'd5, 16'hFFF0);
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b0;
    tick();
    tests_run++;
    if (bus.rs !== 32'h0000_0055 || bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_stall: got rs=%h valid=%b expected 00000055 1",
               bus.rs, bus.out_valid);
    end
    rst_n       = 1'b0;
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd6;
    bus.wb_data = 32'h0000_0099;
    tick();
    rst_n = 1'b1;
    idle();
    bus.out_ready = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.rs !== 32'h0 || bus.rt !== 32'h0 ||
        bus.extended_imm !== 32'h0 || bus.opcode !== 6'h0 || bus.rs_addr !== 5'h0 ||
        bus.rt_addr !== 5'h0) begin
      tests_failed++;
      $display("[TB] FAIL stall_reset: got v=%b rs=%h rt=%h imm=%h op=%h a=%h/%h expected all 0",
               bus.out_valid, bus.rs, bus.rt, bus.extended_imm, bus.opcode,
               bus.rs_addr, bus.rt_addr);
    end
    bus.out_ready   = 1'b1;
    bus.instruction = enc_r(5'd5, 5'd6, 5'd1, 5'd0, 6'h20);
    bus.in_valid    = 1'b1;
    tick();
    idle();
    tests_run++;
    if (bus.rs !== 32'h0 || bus.rt !== 32'h0 || bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_regs: got rs=%h rt=%h valid=%b expected 0 0 1",
               bus.rs, bus.rt, bus.out_valid);
    end
    tick();
  endtask

  task automatic test_random_traffic();
    logic [31:0] r;
    idle();
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.instruction = {6'($urandom_range(8'h08, 8'h0F)), 2'b00, r[23:21],
                         2'b00, r[18:16], r[15:0]};
      bus.out_ready   = ($urandom_range(0, 2) != 0);
      bus.flush       = ($urandom_range(0, 15) == 0);
      bus.wb_en       = ($urandom_range(0, 1) != 0);
      bus.wb_addr     = 5'($urandom_range(0, 7));
      bus.wb_data     = $urandom;
      tick();
      tests_run++;
      if (bus.out_valid !== mvalid || bus.in_ready !== (!mvalid || bus.out_ready)) begin
        tests_failed++;
        $display("[TB] FAIL rand_handshake_%0d: got valid=%b ready=%b expected %b %b",
                 i, bus.out_valid, bus.in_ready, mvalid, (!mvalid || bus.out_ready));
      end
      if (mvalid) begin
        tests_run++;
        if (bus.rs !== held.rs || bus.rt !== held.rt || bus.extended_imm !== held.imm ||
            bus.opcode !== held.opcode || bus.rs_addr !== held.rs_addr ||
            bus.rt_addr !== held.rt_addr || bus.rd_addr !== held.rd_addr ||
            bus.shamt !== held.shamt) begin
          tests_failed++;
          $display("[TB] FAIL rand_data_%0d: got rs=%h rt=%h imm=%h op=%h expected %h %h %h %h",
                   i, bus.rs, bus.rt, bus.extended_imm, bus.opcode,
                   held.rs, held.rt, held.imm, held.opcode);
        end
      end
    end
    idle();
    tick();
  endtask

  initial begin
    rst_n  = 1'b0;
    mvalid = 1'b0;
    newcap = 1'b0;
    held   = '{default: '0};
    foreach (mregs[i]) mregs[i] = 32'h0;
    idle();
    test_reset();
    test_basic_read();
    test_bypass();
    test_back_to_back_imm();
    test_stall_flush();
    test_r0_and_stall_reset();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
